audio_seq_ctrl: RTL

Record/playback sequencer for the WM8731 audio path. Debounces two push buttons and drives the store path's `record_start`/`wr_load` and the play path's `rd_load`/`play_en`. Counts samples moved via `wav_wren`/`wav_rden` and terminates each phase on buffer-full, length limit or user abort. Sits between board keys and the audio top, in the 50 MHz domain.

---
 rtl/audio_ctrl_pkg.sv | 37 +++
 rtl/key_debounce.sv | 49 ++++
 rtl/audio_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/audio_ctrl_pkg.sv
// Shared types for the audio record/playback sequencer: state encoding,
// the registered control-output bundle and default sizing.
package audio_ctrl_pkg;

  localparam int DEF_CNT_W      = 24;
  localparam int DEF_DEB_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REC_LOAD  = 3'd1,
    ST_RECORD    = 3'd2,
    ST_PLAY_LOAD = 3'd3,
    ST_PLAY      = 3'd4
  } state_t;

  typedef struct packed {
    logic record_start;
    logic wr_load;
    logic rd_load;
    logic play_en;
  } ctrl_t;

  // Control outputs are a pure function of the state being entered.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_REC_LOAD:  c.wr_load      = 1'b1;
      ST_RECORD:    c.record_start = 1'b1;
      ST_PLAY_LOAD: c.rd_load      = 1'b1;
      ST_PLAY:      c.play_en      = 1'b1;
      default:      c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button conditioner: 2-flop synchronizer, stability
// counter, and a one-cycle pulse on each debounced press (falling edge).
module key_debounce
  import audio_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_s1    <= i_key_n;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      // Any bounce back to the accepted level restarts the stability window.
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt    <= '0;
        r_stable <= r_s2;
        r_press  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/audio_seq_ctrl.sv
// Record/playback sequencer for the WM8731 path. Define AUDIO_LOOP_PLAY_EN
// to make playback repeat until a key aborts it; otherwise it is single-shot.
module audio_seq_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int LOAD_CYCLES = 16,
  parameter int MAX_SAMPLES = 4_194_304,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock_50m,
  input  logic             rst,
  input  logic             key_rec,
  input  logic             key_play,
  input  logic             voice_write_done,
  input  logic             wav_wren,
  input  logic             wav_rden,
  output logic             record_start,
  output logic             wr_load,
  output logic             rd_load,
  output logic             play_en,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] rec_len
);

  localparam int               LW        = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES + 1) : 1;
  localparam logic [LW-1:0]    LOAD_LAST = LW'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_SAMPLES);

  logic w_rec_evt;
  logic w_play_evt;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rec (
    .i_clk   (clock_50m),
    .i_rst   (rst),
    .i_key_n (key_rec),
    .o_press (w_rec_evt)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
    .i_clk   (clock_50m),
    .i_rst   (rst),
    .i_key_n (key_play),
    .o_press (w_play_evt)
  );

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [LW-1:0]    r_load_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rec_len;
  logic             r_vwd_d;

  logic             w_strobe;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_vwd_rise;

  // Strobes only count in the active phases; the count saturates at the limit.
  assign w_strobe   = ((r_state == ST_RECORD) && wav_wren) ||
                      ((r_state == ST_PLAY)   && wav_rden);
  assign w_cnt_next = (w_strobe && (r_cnt != MAX_CNT)) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_vwd_rise = voice_write_done & ~r_vwd_d;

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ctrl     <= '0;
      r_load_cnt <= '0;
      r_cnt      <= '0;
      r_rec_len  <= '0;
      r_vwd_d    <= 1'b0;
    end else begin
      r_vwd_d <= voice_write_done;
      case (r_state)
        ST_IDLE: begin
          if (w_rec_evt) begin
            r_state    <= ST_REC_LOAD;
            r_ctrl     <= decode_ctrl(ST_REC_LOAD);
            r_load_cnt <= LOAD_LAST;
            r_cnt      <= '0;
          end else if (w_play_evt && (r_rec_len != '0)) begin
            r_state    <= ST_PLAY_LOAD;
            r_ctrl     <= decode_ctrl(ST_PLAY_LOAD);
            r_load_cnt <= LOAD_LAST;
            r_cnt      <= '0;
          end
        end
        ST_REC_LOAD: begin
          r_cnt <= '0;
          if (r_load_cnt == '0) begin
            r_state <= ST_RECORD;
            r_ctrl  <= decode_ctrl(ST_RECORD);
          end else begin
            r_load_cnt <= r_load_cnt - LW'(1);
          end
        end
        ST_RECORD: begin
          r_cnt <= w_cnt_next;
          // A strobe coincident with the stop condition is part of the take.
          if (w_vwd_rise || (w_cnt_next == MAX_CNT) || w_rec_evt) begin
            r_rec_len <= w_cnt_next;
            r_state   <= ST_IDLE;
            r_ctrl    <= decode_ctrl(ST_IDLE);
          end
        end
        ST_PLAY_LOAD: begin
          r_cnt <= '0;
          if (w_rec_evt) begin
            r_state    <= ST_REC_LOAD;
            r_ctrl     <= decode_ctrl(ST_REC_LOAD);
            r_load_cnt <= LOAD_LAST;
          end else if (r_load_cnt == '0) begin
            r_state <= ST_PLAY;
            r_ctrl  <= decode_ctrl(ST_PLAY);
          end else begin
            r_load_cnt <= r_load_cnt - LW'(1);
          end
        end
        ST_PLAY: begin
          r_cnt <= w_cnt_next;
          if (w_rec_evt) begin
            r_state    <= ST_REC_LOAD;
            r_ctrl     <= decode_ctrl(ST_REC_LOAD);
            r_load_cnt <= LOAD_LAST;
            r_cnt      <= '0;
          end else if (w_play_evt) begin
            r_state <= ST_IDLE;
            r_ctrl  <= decode_ctrl(ST_IDLE);
          end else if (w_cnt_next >= r_rec_len) begin
`ifdef AUDIO_LOOP_PLAY_EN
            r_state    <= ST_PLAY_LOAD;
            r_ctrl     <= decode_ctrl(ST_PLAY_LOAD);
            r_load_cnt <= LOAD_LAST;
            r_cnt      <= '0;
`else
            r_state <= ST_IDLE;
            r_ctrl  <= decode_ctrl(ST_IDLE);
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ctrl  <= '0;
        end
      endcase
    end
  end

  assign record_start = r_ctrl.record_start;
  assign wr_load      = r_ctrl.wr_load;
  assign rd_load      = r_ctrl.rd_load;
  assign play_en      = r_ctrl.play_en;
  assign state_o      = r_state;
  assign rec_len      = r_rec_len;

endmodule
